// File: rtl/fault_mem_pkg.sv
// Shared fault-type encodings and counter width for the configurable faulty-SRAM model.
package fault_mem_pkg;

  typedef enum logic [2:0] {
    FT_NONE   = 3'd0,
    FT_SA0    = 3'd1,
    FT_SA1    = 3'd2,
    FT_TF_UP  = 3'd3,
    FT_TF_DN  = 3'd4,
    FT_CF_INV = 3'd5,
    FT_CF_ST  = 3'd6,
    FT_RSVD   = 3'd7
  } fault_type_e;

  localparam int HIT_CNT_W = 16;

endpackage

// File: rtl/fault_mem_slot.sv
// One runtime-programmable fault slot: holds its configuration and produces the
// force/invert masks it contributes to the current access.
module fault_mem_slot
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int BIT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic                  cfg_en,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [BIT_W-1:0]      cfg_bit,
  input  logic [ADDR_WIDTH-1:0] cfg_aggr_addr,
  input  logic [BIT_W-1:0]      cfg_aggr_bit,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [DATA_WIDTH-1:0] aggr_word,
  output logic [ADDR_WIDTH-1:0] vict_addr,
  output logic [BIT_W-1:0]      vict_bit,
  output logic [ADDR_WIDTH-1:0] aggr_addr,
  output logic                  vict_match,
  output logic                  aggr_match,
  output logic [DATA_WIDTH-1:0] wr_force_mask,
  output logic [DATA_WIDTH-1:0] wr_force_val,
  output logic [DATA_WIDTH-1:0] wr_inv_mask,
  output logic [DATA_WIDTH-1:0] rd_force_mask,
  output logic [DATA_WIDTH-1:0] rd_force_val,
  output logic                  remote_inv
);

  logic              en_q;
  fault_type_e       type_q;
  logic [BIT_W-1:0]  aggr_bit_q;
  logic [DATA_WIDTH-1:0] vmask;
  logic              aggr_flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      type_q     <= FT_NONE;
      vict_addr  <= '0;
      vict_bit   <= '0;
      aggr_addr  <= '0;
      aggr_bit_q <= '0;
    end else if (ld) begin
      en_q       <= cfg_en;
      type_q     <= fault_type_e'(cfg_type);
      vict_addr  <= cfg_addr;
      vict_bit   <= cfg_bit;
      aggr_addr  <= cfg_aggr_addr;
      aggr_bit_q <= cfg_aggr_bit;
    end
  end

  assign vmask      = DATA_WIDTH'(1) << vict_bit;
  assign vict_match = en_q && (address == vict_addr);
  assign aggr_match = en_q && (address == aggr_addr);
  assign aggr_flip  = old_word[aggr_bit_q] != new_word[aggr_bit_q];

  always_comb begin
    wr_force_mask = '0;
    wr_force_val  = '0;
    wr_inv_mask   = '0;
    rd_force_mask = '0;
    rd_force_val  = '0;
    remote_inv    = 1'b0;
    case (type_q)
      FT_SA0: if (vict_match) begin
        wr_force_mask = vmask;
        rd_force_mask = vmask;
      end
      FT_SA1: if (vict_match) begin
        wr_force_mask = vmask;
        wr_force_val  = vmask;
        rd_force_mask = vmask;
        rd_force_val  = vmask;
      end
      FT_TF_UP: if (vict_match && !old_word[vict_bit] && new_word[vict_bit]) begin
        wr_force_mask = vmask;
      end
      FT_TF_DN: if (vict_match && old_word[vict_bit] && !new_word[vict_bit]) begin
        wr_force_mask = vmask;
        wr_force_val  = vmask;
      end
      // Own-cell coupling inverts the word being written; otherwise the victim cell is hit directly.
      FT_CF_INV: if (aggr_match && aggr_flip) begin
        if (vict_addr == aggr_addr) wr_inv_mask = vmask;
        else                        remote_inv  = 1'b1;
      end
      FT_CF_ST: if (vict_match && aggr_word[aggr_bit_q]) begin
        rd_force_mask = vmask;
        rd_force_val  = vmask;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fault_mem_cfg.sv
// Behavioural faulty SRAM with NUM_FAULTS programmable fault slots and a saturating
// fault-hit counter; access timing matches the legacy single-fault model.
module fault_mem_cfg
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CAPACITY   = 64,
  parameter int NUM_FAULTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_we,
  input  logic [(NUM_FAULTS > 1 ? $clog2(NUM_FAULTS) : 1)-1:0] cfg_slot,
  input  logic                  cfg_en,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [(DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1)-1:0] cfg_bit,
  input  logic [ADDR_WIDTH-1:0] cfg_aggr_addr,
  input  logic [(DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1)-1:0] cfg_aggr_bit,
  output logic [HIT_CNT_W-1:0]  fault_hits
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < CAPACITY;
  endfunction

  // gold shadows what a fault-free array would hold, so reads can be classed as faulted.
  logic [DATA_WIDTH-1:0] mem  [CAPACITY];
  logic [DATA_WIDTH-1:0] gold [CAPACITY];

  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH-1:0] old_word, gold_word, wr_word, rd_word;
  logic                  remote_any, faulted;

  logic [NUM_FAULTS-1:0] slot_ld, vict_match, aggr_match, remote_inv;
  logic [ADDR_WIDTH-1:0] vict_addr [NUM_FAULTS];
  logic [BIT_W-1:0]      vict_bit  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] aggr_addr [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] aggr_word [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] wr_fm [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] wr_fv [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] wr_im [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] rd_fm [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] rd_fv [NUM_FAULTS];

  assign old_word  = in_range(address) ? mem[address]  : '0;
  assign gold_word = in_range(address) ? gold[address] : '0;

  for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_slot
    assign slot_ld[i]   = cfg_we && (32'(cfg_slot) == i);
    assign aggr_word[i] = in_range(aggr_addr[i]) ? mem[aggr_addr[i]] : '0;

    fault_mem_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BIT_W      (BIT_W)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .ld            (slot_ld[i]),
      .cfg_en        (cfg_en),
      .cfg_type      (cfg_type),
      .cfg_addr      (cfg_addr),
      .cfg_bit       (cfg_bit),
      .cfg_aggr_addr (cfg_aggr_addr),
      .cfg_aggr_bit  (cfg_aggr_bit),
      .address       (address),
      .old_word      (old_word),
      .new_word      (wdata_q),
      .aggr_word     (aggr_word[i]),
      .vict_addr     (vict_addr[i]),
      .vict_bit      (vict_bit[i]),
      .aggr_addr     (aggr_addr[i]),
      .vict_match    (vict_match[i]),
      .aggr_match    (aggr_match[i]),
      .wr_force_mask (wr_fm[i]),
      .wr_force_val  (wr_fv[i]),
      .wr_inv_mask   (wr_im[i]),
      .rd_force_mask (rd_fm[i]),
      .rd_force_val  (rd_fv[i]),
      .remote_inv    (remote_inv[i])
    );
  end

  // Masks applied in slot order so the highest slot has the final say on a shared bit.
  always_comb begin
    wr_word    = wdata_q;
    rd_word    = old_word;
    remote_any = 1'b0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      wr_word = (wr_word & ~wr_fm[i]) | (wr_fv[i] & wr_fm[i]);
      wr_word = wr_word ^ wr_im[i];
      rd_word = (rd_word & ~rd_fm[i]) | (rd_fv[i] & rd_fm[i]);
      if (remote_inv[i] && in_range(vict_addr[i])) remote_any = 1'b1;
    end
  end

  assign faulted = in_range(address) && (|(vict_match | aggr_match)) &&
                   (write_read ? ((wr_word != wdata_q) || remote_any)
                               : (rd_word != gold_word));

  always_ff @(posedge clk) begin
    if (!rst && write_read) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (remote_inv[i] && in_range(vict_addr[i]))
          mem[vict_addr[i]][vict_bit[i]] <= ~mem[vict_addr[i]][vict_bit[i]];
      end
      if (in_range(address)) begin
        mem[address]  <= wr_word;
        gold[address] <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q    <= '0;
      rdata_q    <= '0;
      rdata      <= '0;
      fault_hits <= '0;
    end else begin
      wdata_q <= wdata;
      rdata   <= rdata_q;
      if (!write_read) rdata_q <= in_range(address) ? rd_word : '0;
      if (faulted && (fault_hits != '1)) fault_hits <= fault_hits + HIT_CNT_W'(1);
    end
  end

endmodule
